// File: rtl/rr_sched_pkg.sv
// ---------------------------------------------------------------------------
// rr_sched_pkg
// Shared constants and types for the round-robin scheduler (rr_sched) and
// its rotating-priority picker (rr_pick).
//   N_REQ    : number of requesters (power of two)
//   IDX_W    : log2(N_REQ)
//   MAX_HOLD : longest grant, in cycles, before a forced release
//   HOLD_W   : hold counter width, MAX_HOLD < 2**HOLD_W
//   CNT_W    : width of the pending-request popcount (0..N_REQ)
// ---------------------------------------------------------------------------
package rr_sched_pkg;

    localparam int N_REQ    = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 15;
    localparam int HOLD_W   = 4;
    localparam int CNT_W    = 4;

    localparam logic [HOLD_W-1:0] MAX_HOLD_V = HOLD_W'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search. The search starts one position
// after lowp (the last-served index) and wraps through all N_REQ positions;
// the first set request bit wins.
// Ports:
//   reqs  in  N_REQ  request vector
//   lowp  in  IDX_W  last-served index (lowest priority)
//   found out 1      at least one request bit set
//   idx   out IDX_W  winning index (0 when found=0)
// ---------------------------------------------------------------------------
module rr_pick
    import rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] reqs,
    input  idx_t             lowp,
    output logic             found,
    output idx_t             idx
);

    // rot[k] is the request at distance k+1 past lowp, so rot[0] has the
    // highest priority this round.
    logic [N_REQ-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            localparam idx_t OFF = idx_t'(gi + 1);
            idx_t pos;
            assign pos     = lowp + OFF;   // wraps modulo N_REQ on IDX_W bits
            assign rot[gi] = reqs[pos];
        end
    endgenerate

    idx_t k_sel;

    always_comb begin
        found = 1'b0;
        k_sel = '0;
        // Walk from the lowest-priority slot upward so the last hit,
        // i.e. the smallest distance, is what remains.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                k_sel = idx_t'(k);
            end
        end
    end

    assign idx = found ? (lowp + k_sel + idx_t'(1)) : '0;

endmodule

// File: rtl/rr_sched.sv
// ---------------------------------------------------------------------------
// rr_sched
// Round-robin scheduler sharing one resource among N_REQ requesters.
// In IDLE the next requester after the last-served index is granted; the
// grant is held until the owner asserts done_i, withdraws its request, or
// the hold counter reaches MAX_HOLD. Every release is followed by one idle
// cycle before the next grant.
// Ports:
//   clk_i        in  1      clock
//   rst_i        in  1      synchronous active-high reset
//   reqs_i       in  8      request vector
//   done_i       in  1      owner releases this cycle (ignored in IDLE)
//   gnt_valid_o  out 1      grant active
//   gnt_idx_o    out 3      owner index, 0 when idle
//   gnt_onehot_o out 8      one-hot owner, 0 when idle
//   lowp_o       out 3      last-served index
//   pend_cnt_o   out 4      registered popcount of reqs_i
//   timeout_o    out 1      one-cycle pulse after a forced release
// Optional (macro RR_SCHED_STATS_EN):
//   gnt_total_o  out 16     saturating count of grants issued
//   tmo_total_o  out 8      saturating count of forced releases
// ---------------------------------------------------------------------------
module rr_sched
    import rr_sched_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_REQ-1:0]  reqs_i,
    input  logic              done_i,
    output logic              gnt_valid_o,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic [N_REQ-1:0]  gnt_onehot_o,
    output logic [IDX_W-1:0]  lowp_o,
    output logic [CNT_W-1:0]  pend_cnt_o,
    output logic              timeout_o
`ifdef RR_SCHED_STATS_EN
    ,
    output logic [15:0]       gnt_total_o,
    output logic [7:0]        tmo_total_o
`endif
);

    state_t              state_q,   state_d;
    idx_t                owner_q,   owner_d;
    idx_t                lowp_q,    lowp_d;
    logic [HOLD_W-1:0]   hold_q,    hold_d;
    logic [CNT_W-1:0]    pend_q,    pend_d;
    logic                timeout_q, timeout_d;

    logic pick_found;
    idx_t pick_idx;
    logic grant_start;
    logic release_user;
    logic hold_expired;
    logic tmo_release;

    rr_pick u_pick (
        .reqs  (reqs_i),
        .lowp  (lowp_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and datapath logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lowp_d       = lowp_q;
        hold_d       = hold_q;
        timeout_d    = 1'b0;
        grant_start  = 1'b0;
        release_user = 1'b0;
        hold_expired = 1'b0;
        tmo_release  = 1'b0;

        pend_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend_d = pend_d + CNT_W'(reqs_i[i]);
        end

        case (state_q)
            IDLE: begin
                // Picker only runs from IDLE, which is what enforces the
                // one-cycle gap after every release.
                if (pick_found) begin
                    state_d     = GRANT;
                    owner_d     = pick_idx;
                    hold_d      = HOLD_W'(1);
                    grant_start = 1'b1;
                end
            end
            GRANT: begin
                release_user = done_i || !reqs_i[owner_q];
                hold_expired = (hold_q == MAX_HOLD_V);
                if (release_user || hold_expired) begin
                    state_d     = IDLE;
                    lowp_d      = owner_q;
                    hold_d      = '0;
                    // A voluntary release in the same cycle wins over the
                    // timeout, so no pulse is reported then.
                    tmo_release = !release_user;
                    timeout_d   = !release_user;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            lowp_q    <= idx_t'(N_REQ - 1);
            hold_q    <= '0;
            pend_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lowp_q    <= lowp_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_valid_o = (state_q == GRANT);
    assign gnt_idx_o   = gnt_valid_o ? owner_q : '0;
    assign lowp_o      = lowp_q;
    assign pend_cnt_o  = pend_q;
    assign timeout_o   = timeout_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign gnt_onehot_o[gi] = gnt_valid_o && (owner_q == idx_t'(gi));
        end
    endgenerate

`ifdef RR_SCHED_STATS_EN
    logic [15:0] gnt_total_q, gnt_total_d;
    logic [7:0]  tmo_total_q, tmo_total_d;

    // Both counters saturate at all-ones.
    always_comb begin
        gnt_total_d = gnt_total_q;
        tmo_total_d = tmo_total_q;
        if (grant_start && (gnt_total_q != '1)) begin
            gnt_total_d = gnt_total_q + 16'd1;
        end
        if (tmo_release && (tmo_total_q != '1)) begin
            tmo_total_d = tmo_total_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_total_q <= '0;
            tmo_total_q <= '0;
        end else begin
            gnt_total_q <= gnt_total_d;
            tmo_total_q <= tmo_total_d;
        end
    end

    assign gnt_total_o = gnt_total_q;
    assign tmo_total_o = tmo_total_q;
`else
    logic unused_stats;
    assign unused_stats = grant_start ^ tmo_release;
`endif

endmodule

// File: tb/tb_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_rr_sched
// Directed bench for rr_sched. Inputs change and outputs are sampled 1 ns
// after each rising edge; expected values are written out by hand.
// Connects the statistics ports when RR_SCHED_STATS_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_sched;

    logic       clk;
    logic       rst;
    logic [7:0] reqs;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic [2:0] lowp;
    logic [3:0] pend_cnt;
    logic       timeout;
`ifdef RR_SCHED_STATS_EN
    logic [15:0] gnt_total;
    logic [7:0]  tmo_total;
`endif

    int errors = 0;
    int checks = 0;

    rr_sched dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .reqs_i       (reqs),
        .done_i       (done),
        .gnt_valid_o  (gnt_valid),
        .gnt_idx_o    (gnt_idx),
        .gnt_onehot_o (gnt_onehot),
        .lowp_o       (lowp),
        .pend_cnt_o   (pend_cnt),
        .timeout_o    (timeout)
`ifdef RR_SCHED_STATS_EN
        ,
        .gnt_total_o  (gnt_total),
        .tmo_total_o  (tmo_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant active for requester e.
    task automatic chk_grant(input string tag, input int unsigned e);
        chk({tag, "_valid"},  32'(gnt_valid), 1);
        chk({tag, "_idx"},    32'(gnt_idx), e);
        chk({tag, "_onehot"}, 32'(gnt_onehot), 32'(1) << e);
    endtask

    // Idle with last-served index l and given timeout pulse value.
    task automatic chk_idle(input string tag, input int unsigned l, input int unsigned t);
        chk({tag, "_valid"},   32'(gnt_valid), 0);
        chk({tag, "_idx"},     32'(gnt_idx), 0);
        chk({tag, "_onehot"},  32'(gnt_onehot), 0);
        chk({tag, "_lowp"},    32'(lowp), l);
        chk({tag, "_timeout"}, 32'(timeout), t);
    endtask

    initial begin
        rst  = 1'b1;
        reqs = 8'h00;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        chk_idle("reset", 7, 0);
        chk("reset_pend", 32'(pend_cnt), 0);
        $display("step reset: lowp=%0d", lowp);

        // No requests: stays idle.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle("noreq", 7, 0);
            chk("noreq_pend", 32'(pend_cnt), 0);
        end
        $display("step idle-no-request: 5 cycles");

        // All requesting, done after each grant: strict rotation 0..7,0.
        reqs = 8'hFF;
        tick();
        for (int i = 0; i < 9; i++) begin
            chk_grant("rot", i % 8);
            chk("rot_pend", 32'(pend_cnt), 8);
            done = 1'b1;
            tick();
            chk_idle("rot_rel", i % 8, 0);
            done = 1'b0;
            if (i == 8) reqs = 8'h00;
            tick();
            $display("step rotation: granted %0d", i % 8);
        end
        chk_idle("rot_end", 0, 0);

        // Reach lowp=5, then requests {5,0}: wrap gives 0 first, then 5.
        reqs = 8'h20;
        tick();
        chk_grant("set5", 5);
        done = 1'b1;
        tick();
        chk_idle("set5_rel", 5, 0);
        done = 1'b0;
        reqs = 8'b0010_0001;
        tick();
        chk_grant("wrap0", 0);
        chk("wrap0_pend", 32'(pend_cnt), 2);
        done = 1'b1;
        tick();
        chk_idle("wrap0_rel", 0, 0);
        done = 1'b0;
        tick();
        chk_grant("wrap5", 5);
        done = 1'b1;
        tick();
        chk_idle("wrap5_rel", 5, 0);
        done = 1'b0;
        reqs = 8'h00;
        tick();
        $display("step wrap: order 0 then 5");

        // Requester 3 holds: 15 grant cycles, timeout pulse, re-grant.
        reqs = 8'h08;
        tick();
        for (int c = 1; c <= 15; c++) begin
            chk_grant("hold", 3);
            chk("hold_timeout", 32'(timeout), 0);
            tick();
        end
        chk_idle("hold_tmo", 3, 1);
        tick();
        chk_grant("hold_regrant", 3);
        chk("hold_regrant_timeout", 32'(timeout), 0);
`ifdef RR_SCHED_STATS_EN
        chk("stats_gnt", 32'(gnt_total), 14);
        chk("stats_tmo", 32'(tmo_total), 1);
`endif
        reqs = 8'h00;
        tick();
        chk_idle("hold_withdraw", 3, 0);
        $display("step timeout: 15-cycle hold then pulse");

        // Requester 2 withdraws on its 4th grant cycle.
        reqs = 8'h04;
        tick();
        chk_grant("wd_c1", 2);
        tick();
        chk_grant("wd_c2", 2);
        tick();
        chk_grant("wd_c3", 2);
        reqs = 8'h00;
        tick();
        chk_idle("wd_rel", 2, 0);
        $display("step withdraw: released idx 2");

        // Reset in the middle of a grant.
        reqs = 8'h40;
        tick();
        chk_grant("rstg", 6);
        rst = 1'b1;
        tick();
        chk_idle("rstg_after", 7, 0);
        chk("rstg_pend", 32'(pend_cnt), 0);
`ifdef RR_SCHED_STATS_EN
        chk("rstg_gnt_total", 32'(gnt_total), 0);
        chk("rstg_tmo_total", 32'(tmo_total), 0);
`endif
        rst  = 1'b0;
        reqs = 8'h00;
        tick();
        chk_idle("rstg_idle", 7, 0);
        $display("step reset-mid-grant: lowp=%0d", lowp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_sched.md
Name: rr_sched

Overview:
- Sequential round-robin scheduler that shares one resource between 8 requesters.
- Picks the next requester after the last-served index, locks the grant until the owner releases or a hold limit expires, then advances the pointer.
- Sits in front of the shared datapath and drives its select/enable; also reports pending-request count and timeouts.

Parameters:
- N_REQ, 8, number of requesters (fixed at 8 for this revision; must be a power of 2)
- IDX_W, 3, index width, equals log2(N_REQ)
- MAX_HOLD, 15, maximum grant length in cycles before forced release (1..15)
- HOLD_W, 4, hold counter width; must satisfy MAX_HOLD < 2**HOLD_W

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- reqs_i  in  8  request vector, bit i = requester i
- done_i  in  1  current owner releases the resource this cycle
- gnt_valid_o  out  1  a grant is active
- gnt_idx_o  out  3  index of current owner; 0 when gnt_valid_o=0
- gnt_onehot_o  out  8  one-hot of owner; all-zero when idle
- lowp_o  out  3  last-served index (lowest priority next round)
- pend_cnt_o  out  4  registered count of set bits in reqs_i (0..8)
- timeout_o  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE; gnt_valid_o=0; gnt_idx_o=0; gnt_onehot_o=0; lowp_o=7, so requester 0 has first priority; pend_cnt_o=0; timeout_o=0; hold counter=0.
  - Reset mid-grant drops the grant at that same edge.
- FSM states: IDLE and GRANT.
- IDLE:
  - Search starts at lowp_o+1 (mod 8) and wraps through all 8 positions. The first set bit of reqs_i wins.
  - If any bit is set: next state=GRANT, owner=winner, hold counter=1. Grant outputs become valid after the same edge (1-cycle latency from request to grant).
  - If reqs_i=0, stay in IDLE.
- GRANT: release occurs at an edge when any of these holds:
  - done_i=1
  - reqs_i[owner]=0 (requester withdrew)
  - hold counter == MAX_HOLD (timeout)
- On release:
  - lowp_o <= owner; state <= IDLE; grant outputs clear.
  - On timeout, timeout_o=1 for exactly the next cycle, unless done_i or withdrawal happened the same cycle; those take precedence and suppress timeout_o.
  - Mandatory 1-cycle idle gap between grants: no back-to-back grant in the release cycle.
- Otherwise in GRANT, the hold counter increments; grant outputs are stable.
- done_i in IDLE is ignored.
- Requests from non-owners in GRANT have no effect until IDLE.
- Single requester: repeatedly granted, with one idle gap between grants.
- All 8 requesting with every grant released by done_i after 1 cycle: grant order is 0,1,...,7,0 (strict rotation).
- pend_cnt_o: registered popcount of all 8 bits of reqs_i, one cycle behind the input.
- Wrap-around: lowp_o=7 gives search order 0..7; index arithmetic is modulo 8 on IDX_W bits.

Optional Feature:
- Macro RR_SCHED_STATS_EN.
- Defined:
  - Adds outputs gnt_total_o (16) and tmo_total_o (8).
  - Saturating counters: gnt_total_o increments on each IDLE->GRANT transition; tmo_total_o increments on each timeout release. Both hold at all-ones.
  - Both reset to 0 on rst_i.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package rr_sched_pkg: N_REQ, IDX_W, MAX_HOLD defaults; typedef enum logic {IDLE, GRANT} state_t; typedef logic [IDX_W-1:0] idx_t.
- Sub-module rr_pick: combinational, in (reqs, lowp), out (found, idx). Rotating priority search; instantiated once.

Test Plan:
- Reset, then reqs_i=8'h00 for 5 cycles -> gnt_valid_o=0, lowp_o=7, pend_cnt_o=0 throughout.
- reqs_i=8'hFF, done_i pulsed 1 cycle after each grant -> gnt_idx_o sequence 0,1,2,...,7,0 with one idle cycle between grants; pend_cnt_o=8.
- lowp_o=5 (reached after serving 5), reqs_i=8'b0010_0001 -> grant idx 0 (wrap skips 5), lowp_o becomes 0; next grant idx 5.
- reqs_i=8'h08 held, done_i=0 -> grant idx 3 for exactly 15 cycles, then timeout_o=1 for one cycle, idle cycle, re-grant idx 3.
- Grant idx 2 active, reqs_i[2] dropped on cycle 4 -> release at that edge, timeout_o=0, lowp_o=2.
- rst_i asserted during GRANT -> at next edge all outputs at reset values, lowp_o=7; with RR_SCHED_STATS_EN, counters read 0.
